biquad_filter: RTL and testbench

- Single-section second-order IIR filter (Direct Form I), one sample per clock.
- Signed fixed-point coefficients, set by parameters.
- Instances cascade directly (output of one feeds input of the next) to build higher-order filters, e.g. audio band-pass banks.
- Fully pipelined: no handshake, one new sample accepted every clock.

---
 rtl/biquad_filter.sv | 73 +++++++
 tb/tb_biquad_filter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/biquad_filter.sv
// Direct Form I biquad IIR section, one sample per clock; BIQUAD_SAT_EN selects saturating output limiting instead of wrap.
// Latency: 1 clock, combinational MAC into the output register; no backpressure, a new sample is taken every edge.
module biquad_filter #(
  parameter int DATA_W    = 24,
  parameter int COEF_W    = 32,
  parameter int FRAC_BITS = 20,
  parameter logic signed [COEF_W-1:0] b0 = '0,
  parameter logic signed [COEF_W-1:0] b1 = '0,
  parameter logic signed [COEF_W-1:0] b2 = '0,
  parameter logic signed [COEF_W-1:0] a1 = '0,
  parameter logic signed [COEF_W-1:0] a2 = '0
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic signed [DATA_W-1:0] sample_in,
  output logic signed [DATA_W-1:0] sample_out
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + 3;
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) <<< (FRAC_BITS - 1);

  logic signed [DATA_W-1:0] x1, x2, y2;
  logic signed [PROD_W-1:0] p_b0, p_b1, p_b2, p_a1, p_a2;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] y_new;

  // Operands are widened first so every product is exact in PROD_W bits.
  always_comb begin
    p_b0 = PROD_W'(sample_in)  * PROD_W'(b0);
    p_b1 = PROD_W'(x1)         * PROD_W'(b1);
    p_b2 = PROD_W'(x2)         * PROD_W'(b2);
    p_a1 = PROD_W'(sample_out) * PROD_W'(a1);
    p_a2 = PROD_W'(y2)         * PROD_W'(a2);
    acc  = ACC_W'(p_b0) + ACC_W'(p_b1) + ACC_W'(p_b2)
         - ACC_W'(p_a1) - ACC_W'(p_a2) + RND;
  end

`ifdef BIQUAD_SAT_EN
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] Y_MIN = -(ACC_W'(64'sd1 <<< (DATA_W - 1)));

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = acc >>> FRAC_BITS;
    if (shifted > Y_MAX)      y_new = Y_MAX[DATA_W-1:0];
    else if (shifted < Y_MIN) y_new = Y_MIN[DATA_W-1:0];
    else                      y_new = shifted[DATA_W-1:0];
  end
`else
  // Two's-complement wrap: keep only the low DATA_W bits of the rounded sum.
  always_comb begin
    y_new = DATA_W'(acc >>> FRAC_BITS);
  end
`endif

  // sample_out doubles as y[n-1]; feedback sees exactly the limited output.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      x1         <= '0;
      x2         <= '0;
      y2         <= '0;
      sample_out <= '0;
    end else begin
      x1         <= sample_in;
      x2         <= x1;
      y2         <= sample_out;
      sample_out <= y_new;
    end
  end

endmodule

// File: tb/tb_biquad_filter.sv
// Directed table-driven bench for biquad_filter: identity, feedback rounding, FIR taps,
// cascaded band-pass and overflow limiting, each on its own parameterised instance.
module tb_biquad_filter;

  localparam int W = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic signed [W-1:0] x_id, y_id, x_fb, y_fb, x_fir, y_fir;
  logic signed [W-1:0] x_bp, y_bp1, y_bp2, x_ov, y_ov;

  int n_vec = 0;
  int n_err = 0;

  biquad_filter #(.b0(32'sd1048576)) u_id (
    .clk_in(clk), .rst_in(rst_n), .sample_in(x_id), .sample_out(y_id));

  biquad_filter #(.b0(32'sd1048576), .a1(-32'sd524288)) u_fb (
    .clk_in(clk), .rst_in(rst_n), .sample_in(x_fb), .sample_out(y_fb));

  biquad_filter #(.b0(32'sd1048576), .b1(32'sd1048576), .b2(32'sd1048576)) u_fir (
    .clk_in(clk), .rst_in(rst_n), .sample_in(x_fir), .sample_out(y_fir));

  biquad_filter #(.b0(32'sd75467), .b2(-32'sd75467), .a1(-32'sd1237071), .a2(32'sd937178)) u_bp1 (
    .clk_in(clk), .rst_in(rst_n), .sample_in(x_bp), .sample_out(y_bp1));

  biquad_filter #(.b0(32'sd75467), .b2(-32'sd75467), .a1(-32'sd1403483), .a2(32'sd946853)) u_bp2 (
    .clk_in(clk), .rst_in(rst_n), .sample_in(y_bp1), .sample_out(y_bp2));

  biquad_filter #(.b0(32'sd2097152)) u_ov (
    .clk_in(clk), .rst_in(rst_n), .sample_in(x_ov), .sample_out(y_ov));

  typedef struct {
    logic signed [W-1:0] x_id;
    logic signed [W-1:0] e_id;
    logic signed [W-1:0] x_fb;
    logic signed [W-1:0] e_fb;
    logic signed [W-1:0] x_fir;
    logic signed [W-1:0] e_fir;
  } vec_t;

  localparam int NROWS = 13;
  vec_t tbl [NROWS];

  function automatic vec_t row(int xi, int ei, int xf, int ef, int xr, int er);
    vec_t r;
    r.x_id  = W'(xi);
    r.e_id  = W'(ei);
    r.x_fb  = W'(xf);
    r.e_fb  = W'(ef);
    r.x_fir = W'(xr);
    r.e_fir = W'(er);
    return r;
  endfunction

  task automatic check(input string name, input logic signed [W-1:0] act,
                       input logic signed [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%06h), expected %0d (0x%06h)", name, act, act, exp, exp);
    end
  endtask

  task automatic zero_inputs();
    x_id  = '0;
    x_fb  = '0;
    x_fir = '0;
    x_bp  = '0;
    x_ov  = '0;
  endtask

  // Reset asserted for one cycle, released at a falling edge.
  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    zero_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int max_bp1, max_bp2, a1v, a2v;

  initial begin
    // identity, feedback impulse (halving with round-half-up), FIR step 10
    tbl[0]  = row(100,      100,      1000, 1000, 10, 10);
    tbl[1]  = row(-200,     -200,     0,    500,  10, 20);
    tbl[2]  = row(300,      300,      0,    250,  10, 30);
    tbl[3]  = row(1193046,  1193046,  0,    125,  10, 30);
    tbl[4]  = row(-8388608, -8388608, 0,    63,   10, 30);
    tbl[5]  = row(8388607,  8388607,  0,    32,   10, 30);
    tbl[6]  = row(0,        0,        0,    16,   10, 30);
    tbl[7]  = row(-1,       -1,       0,    8,    10, 30);
    tbl[8]  = row(1,        1,        0,    4,    10, 30);
    tbl[9]  = row(5,        5,        0,    2,    10, 30);
    tbl[10] = row(-5,       -5,       0,    1,    10, 30);
    tbl[11] = row(4194304,  4194304,  0,    1,    10, 30);
    tbl[12] = row(-4194304, -4194304, 0,    1,    10, 30);

    rst_n = 1'b0;
    zero_inputs();
    x_id = 24'sh123456;
    #12;
    check("reset_id", y_id, '0);
    check("reset_fb", y_fb, '0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_after_reset", y_id, 24'sh123456);

    // Asynchronous assertion mid-cycle, no clock edge in between.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", y_id, '0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NROWS; i++) begin
      x_id  = tbl[i].x_id;
      x_fb  = tbl[i].x_fb;
      x_fir = tbl[i].x_fir;
      @(posedge clk);
      #1;
      check($sformatf("identity[%0d]", i), y_id,  tbl[i].e_id);
      check($sformatf("feedback[%0d]", i), y_fb,  tbl[i].e_fb);
      check($sformatf("fir[%0d]", i),      y_fir, tbl[i].e_fir);
      @(negedge clk);
    end

    // Band-pass step response through two cascaded sections.
    pulse_reset();
    x_bp = 24'sh020000;
    @(posedge clk);
    #1;
    check("bp1_first", y_bp1, 24'sd9433);
    check("bp2_first", y_bp2, 24'sd0);
    @(posedge clk);
    #1;
    check("bp1_second", y_bp1, 24'sd20562);
    check("bp2_second", y_bp2, 24'sd679);
    max_bp1 = 0;
    max_bp2 = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      a1v = (y_bp1 < 0) ? -int'(y_bp1) : int'(y_bp1);
      a2v = (y_bp2 < 0) ? -int'(y_bp2) : int'(y_bp2);
      if (a1v > max_bp1) max_bp1 = a1v;
      if (a2v > max_bp2) max_bp2 = a2v;
    end
    n_vec++;
    if (max_bp1 >= (1 << 21) || max_bp2 >= (1 << 21)) begin
      n_err++;
      $display("FAIL bp_bounded: peak |y| %0d / %0d, required below %0d", max_bp1, max_bp2, 1 << 21);
    end
    n_vec++;
    if (max_bp1 < 9433) begin
      n_err++;
      $display("FAIL bp_rings: peak |y1| %0d, required at least 9433", max_bp1);
    end
    n_vec++;
    if (a1v > 64 || a2v > 64) begin
      n_err++;
      $display("FAIL bp_decay: final |y| %0d / %0d, required at most 64", a1v, a2v);
    end

    // Gain of 2 on a large input overflows DATA_W.
    pulse_reset();
    x_ov = 24'sh500000;
    @(posedge clk);
    #1;
`ifdef BIQUAD_SAT_EN
    check("overflow_pos", y_ov, 24'sh7FFFFF);
`else
    check("overflow_pos", y_ov, 24'shA00000);
`endif
    @(negedge clk);
    x_ov = -24'sh500000;
    @(posedge clk);
    #1;
`ifdef BIQUAD_SAT_EN
    check("overflow_neg", y_ov, 24'sh800000);
`else
    check("overflow_neg", y_ov, 24'sh600000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
